sram_ctrl_param: RTL and testbench
==================================

// Module: sram_ctrl_param
// PURPOSE
//  Parametrised controller for the board's asynchronous SRAM (Nexys2 class, 18-bit adr, 16-bit data).
//  Replaces the fixed single-access test controller with a valid/ready request port, programmable
//  read/write wait states and per-byte enables. Sits between on-chip masters (switch/button
//  test logic, CPU bus) and the external SRAM pins. Handles one access at a time, with no reordering.
// PARAMETERS
//  ADDR_W   18  SRAM word address width
//  DATA_W   16  data width; multiple of 8; BE_W = DATA_W/8
//  RD_WAIT  2   cycles OE_n/CE_n held low per read; range 1..15
//  WR_WAIT  2   cycles WE_n held low per write; range 1..15
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept a request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_adr    in   ADDR_W  word address
//  req_wdat   in   DATA_W  write data
//  req_be     in   BE_W    byte enables, active-high; bit0 = bits 7:0
//  rsp_valid  out  1       one-cycle pulse; rsp_rdat valid
//  rsp_rdat   out  DATA_W  read data, held until next read completes
//  busy       out  1       state != IDLE
//  sram_adr   out  ADDR_W  SRAM address, registered
//  sram_dat   inout DATA_W SRAM data bus; driven only in WRITE/WR_HOLD, else Z
//  sram_ce_n, sram_oe_n, sram_we_n  out 1  active-low strobes, registered
//  sram_be_n  out  BE_W    active-low byte lanes (16-bit: [1]=UB, [0]=LB)
// BEHAVIOUR
//  - Reset (while high and the following cycle's outputs): ce_n=oe_n=we_n=1, be_n=all 1, sram_adr=0,
//    bus Z, rsp_valid=0, rsp_rdat=0, req_ready=0, state=IDLE. req_ready=1 from the first cycle after reset drops.
//  - req_ready = (state==IDLE) & ~reset. Accept on req_valid & req_ready; latch adr/wdat/be/we.
//  - FSM: IDLE -> READ or WRITE; READ -(RD_WAIT cycles)-> IDLE; WRITE -(WR_WAIT)-> WR_HOLD -(1)-> IDLE.
//  - READ: ce_n=0, oe_n=0, be_n=~be, adr stable for all RD_WAIT cycles; sram_dat sampled on the
//    last READ edge; rsp_valid=1 on the following cycle (accept at n -> rsp_valid at n+RD_WAIT+1).
//  - WRITE: ce_n=0, we_n=0, oe_n=1, bus driven with wdat for WR_WAIT cycles.
//  - WR_HOLD: we_n=1, ce_n=0, adr and bus still held (hold time), then bus released.
//  - IDLE: ce_n=oe_n=we_n=1, be_n all 1, bus Z; sram_adr keeps its last value.
//  - Back-to-back: a request may be accepted in the same cycle rsp_valid is high.
//  - req_be==0: access still runs full timing with all lanes disabled; reads return rsp_valid.
//  - Address wraps naturally at 2^ADDR_W; no range check.
//  - Reset mid-access: abort immediately, strobes high next edge, no rsp_valid, bus Z.
//  - oe_n and we_n are never low in the same cycle; the bus is never driven while oe_n=0.
// CONFIGURATION
//  SRAM_CTRL_TURNAROUND_EN defined: FSM adds TURN state (1 idle cycle, all strobes high, bus Z)
//    after WR_HOLD when the next accepted request is a read, and after READ when the next is a write;
//    req_ready=0 during TURN. Same-direction sequences are unaffected.
//  Undefined: no TURN state; opposite-direction access may start on the cycle after IDLE accept.
// TESTING
//  1 write adr 0x00012 wdat 0xABCD be 2'b11 -> we_n low exactly 2 cycles, bus 0xABCD for 3 cycles, be_n 2'b00.
//  2 read adr 0x00012, model drives 0x00F0 while oe_n=0 -> rsp_valid cycle n+3, rsp_rdat 0x00F0.
//  3 write be 2'b10 -> be_n 2'b01 (UB low, LB high); be 2'b00 -> be_n 2'b11, full timing.
//  4 reset asserted in 2nd READ cycle -> strobes high next edge, no rsp_valid, req_ready 1 after release.
//  5 write then read back-to-back; _EN off: oe_n low 1 cycle after WR_HOLD; on: 1 extra idle cycle.
//  6 RD_WAIT=4, WR_WAIT=1, adr 0x3FFFF -> oe_n low 4 cycles, we_n low 1, sram_adr 0x3FFFF.

Source files
------------

// File: rtl/sram_ctrl_param.sv
// Valid/ready controller for an asynchronous SRAM with programmable read/write wait states.
// Define SRAM_CTRL_TURNAROUND_EN to insert one idle bus-turnaround cycle between opposite directions.
module sram_ctrl_param #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_adr,
  input  logic [DATA_W-1:0]   req_wdat,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdat,
  output logic                busy,
  output logic [ADDR_W-1:0]   sram_adr,
  inout  wire  [DATA_W-1:0]   sram_dat,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [3:0] RdLast = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrLast = 4'(WR_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StWrHold, StTurn} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [DATA_W-1:0] wdat_q;
  logic [BE_W-1:0]   be_q;
  logic              dat_oe_q;
`ifdef SRAM_CTRL_TURNAROUND_EN
  logic              last_vld_q;
  logic              last_we_q;
`endif

  logic            accept;
  logic            turn;
  logic            go;
  logic            start_we;
  logic [BE_W-1:0] start_be;

  assign req_ready = (state_q == StIdle) & ~reset;
  assign busy      = (state_q != StIdle);
  assign accept    = req_valid & req_ready;
  assign sram_dat  = dat_oe_q ? wdat_q : {DATA_W{1'bz}};

  // An access starts either straight from an IDLE accept or after the turnaround cycle.
  always_comb begin
    turn = 1'b0;
`ifdef SRAM_CTRL_TURNAROUND_EN
    turn = last_vld_q & (req_we != last_we_q);
`endif
    go       = (state_q == StTurn) | (accept & ~turn);
    start_we = (state_q == StTurn) ? we_q : req_we;
    start_be = (state_q == StTurn) ? be_q : req_be;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      be_q      <= '0;
      dat_oe_q  <= 1'b0;
      sram_adr  <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      rsp_valid <= 1'b0;
      rsp_rdat  <= '0;
`ifdef SRAM_CTRL_TURNAROUND_EN
      last_vld_q <= 1'b0;
      last_we_q  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q     <= req_we;
            wdat_q   <= req_wdat;
            be_q     <= req_be;
            sram_adr <= req_adr;
            state_q  <= StTurn;
          end
        end
        StTurn: ;
        StRead: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StIdle;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
            rsp_valid <= 1'b1;
            rsp_rdat  <= sram_dat;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWrite: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StWrHold;
            sram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWrHold: begin
          state_q   <= StIdle;
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          dat_oe_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // Overrides the IDLE/TURN next state when the access actually begins.
      if (go) begin
        sram_ce_n <= 1'b0;
        sram_be_n <= ~start_be;
        if (start_we) begin
          state_q   <= StWrite;
          cnt_q     <= WrLast;
          sram_we_n <= 1'b0;
          dat_oe_q  <= 1'b1;
        end else begin
          state_q   <= StRead;
          cnt_q     <= RdLast;
          sram_oe_n <= 1'b0;
        end
`ifdef SRAM_CTRL_TURNAROUND_EN
        last_vld_q <= 1'b1;
        last_we_q  <= start_we;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: two instances (default waits, and RD_WAIT=4/WR_WAIT=1) against a
// cycle-timeline model built from the access rules, plus pinned literal expectations.
`timescale 1ns/1ps
module tb_sram_ctrl_param;

  localparam int N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [17:0] req_adr = '0;
  logic [15:0] req_wdat = '0;
  logic [1:0]  req_be = '0;

  logic        ready [2];
  logic        rsp_v [2];
  logic        busy  [2];
  logic        ce_n  [2];
  logic        oe_n  [2];
  logic        we_n  [2];
  logic [15:0] rdat  [2];
  logic [17:0] adr   [2];
  logic [1:0]  be_n  [2];
  wire  [15:0] dat0;
  wire  [15:0] dat1;

  // SRAM stand-in: returns address-derived data while selected and output-enabled.
  assign dat0 = (!ce_n[0] && !oe_n[0]) ? (adr[0][15:0] ^ 16'h00E2) : 16'hzzzz;
  assign dat1 = (!ce_n[1] && !oe_n[1]) ? (adr[1][15:0] ^ 16'h00E2) : 16'hzzzz;

  sram_ctrl_param dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[0]), .req_we(req_we),
    .req_adr(req_adr), .req_wdat(req_wdat), .req_be(req_be), .rsp_valid(rsp_v[0]),
    .rsp_rdat(rdat[0]), .busy(busy[0]), .sram_adr(adr[0]), .sram_dat(dat0),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
  );

  sram_ctrl_param #(.RD_WAIT(4), .WR_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[1]), .req_we(req_we),
    .req_adr(req_adr), .req_wdat(req_wdat), .req_be(req_be), .rsp_valid(rsp_v[1]),
    .rsp_rdat(rdat[1]), .busy(busy[1]), .sram_adr(adr[1]), .sram_dat(dat1),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected output timeline per instance, indexed by cycle.
  logic        e_ce  [2][N];
  logic        e_oe  [2][N];
  logic        e_we  [2][N];
  logic        e_drv [2][N];
  logic        e_rsp [2][N];
  logic [1:0]  e_be  [2][N];
  logic [15:0] e_dat [2][N];
  logic [15:0] e_rdat[2][N];
  logic [17:0] e_adr [2][N];
  int          free_at [2];
  logic        last_vld[2];
  logic        last_we [2];

  // Literal-check statistics, cleared by the driver.
  int we_low[2], oe_low[2], abcd_cnt[2], rsp_cnt[2], rsp_cyc[2], first_oe[2];
  logic [1:0] be_at_we[2];
  int acc_cyc;

  function automatic int rd_wait(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int wr_wait(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int i, input int c0);
    for (int c = c0; c < N; c++) begin
      e_ce[i][c] = 1'b1;  e_oe[i][c] = 1'b1;  e_we[i][c] = 1'b1;  e_drv[i][c] = 1'b0;
      e_rsp[i][c] = 1'b0; e_be[i][c] = 2'b11; e_dat[i][c] = '0;   e_rdat[i][c] = '0;
      e_adr[i][c] = '0;
    end
  endtask

  task automatic schedule(input int i, input int n, input logic we, input logic [17:0] a,
                          input logic [15:0] wd, input logic [1:0] be);
    int s;
    int w;
    s = n + 1;
`ifdef SRAM_CTRL_TURNAROUND_EN
    if (last_vld[i] && (we != last_we[i])) s++;
`endif
    last_vld[i] = 1'b1;
    last_we[i]  = we;
    for (int c = n + 1; c < N; c++) e_adr[i][c] = a;
    if (we) begin
      w = wr_wait(i);
      for (int c = s; c <= s + w && c < N; c++) begin
        e_ce[i][c] = 1'b0; e_we[i][c] = (c == s + w); e_be[i][c] = ~be;
        e_drv[i][c] = 1'b1; e_dat[i][c] = wd;
      end
      free_at[i] = s + w + 1;
    end else begin
      w = rd_wait(i);
      for (int c = s; c < s + w && c < N; c++) begin
        e_ce[i][c] = 1'b0; e_oe[i][c] = 1'b0; e_be[i][c] = ~be;
      end
      if (s + w < N) e_rsp[i][s + w] = 1'b1;
      for (int c = s + w; c < N; c++) e_rdat[i][c] = a[15:0] ^ 16'h00E2;
      free_at[i] = s + w;
    end
  endtask

  // Compare process: check every output each cycle, then advance the model.
  initial begin
    logic [15:0] dv;
    for (int i = 0; i < 2; i++) begin
      clear_from(i, 0);
      free_at[i] = 0; last_vld[i] = 1'b0; last_we[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (cyc < N - 1) begin
        for (int i = 0; i < 2; i++) begin
          dv = (i == 0) ? dat0 : dat1;
          chk("req_ready", i, {31'd0, ready[i]}, {31'd0, !reset && cyc >= free_at[i]});
          if (!reset) chk("busy", i, {31'd0, busy[i]}, {31'd0, cyc < free_at[i]});
          chk("ce_n", i, {31'd0, ce_n[i]}, {31'd0, e_ce[i][cyc]});
          chk("oe_n", i, {31'd0, oe_n[i]}, {31'd0, e_oe[i][cyc]});
          chk("we_n", i, {31'd0, we_n[i]}, {31'd0, e_we[i][cyc]});
          chk("be_n", i, {30'd0, be_n[i]}, {30'd0, e_be[i][cyc]});
          chk("sram_adr", i, {14'd0, adr[i]}, {14'd0, e_adr[i][cyc]});
          chk("rsp_valid", i, {31'd0, rsp_v[i]}, {31'd0, e_rsp[i][cyc]});
          chk("rsp_rdat", i, {16'd0, rdat[i]}, {16'd0, e_rdat[i][cyc]});
          if (e_drv[i][cyc]) chk("sram_dat", i, {16'd0, dv}, {16'd0, e_dat[i][cyc]});

          if (!we_n[i]) begin we_low[i]++; be_at_we[i] = be_n[i]; end
          if (!oe_n[i]) begin oe_low[i]++; if (first_oe[i] < 0) first_oe[i] = cyc; end
          if (dv === 16'hABCD) abcd_cnt[i]++;
          if (rsp_v[i]) begin rsp_cnt[i]++; rsp_cyc[i] = cyc; end

          if (reset) begin
            clear_from(i, cyc + 1);
            free_at[i] = cyc + 1;
            last_vld[i] = 1'b0;
          end else if (req_valid && cyc >= free_at[i]) begin
            schedule(i, cyc, req_we, req_adr, req_wdat, req_be);
          end
        end
      end
      cyc++;
    end
  end

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      we_low[i] = 0; oe_low[i] = 0; abcd_cnt[i] = 0; rsp_cnt[i] = 0;
      rsp_cyc[i] = -1; first_oe[i] = -1; be_at_we[i] = 2'bxx;
    end
  endtask

  // Hold a request until instance 0 takes it (bounded), then drop valid.
  task automatic send(input logic we, input logic [17:0] a, input logic [15:0] wd,
                      input logic [1:0] be);
    logic got;
    got = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_adr = a; req_wdat = wd; req_be = be;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk); #1;
      if (ready[0]) begin got = 1'b1; acc_cyc = cyc - 1; end
    end
    chk("accept", 0, {31'd0, got}, 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk); #1;
  endtask

  initial begin
    int a1;
    int a2;
    clr_stats();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Full-lane write, both wait profiles.
    clr_stats();
    send(1'b1, 18'h00012, 16'hABCD, 2'b11);
    idle(8);
    chk("t1_we_low", 0, we_low[0], 32'd2);
    chk("t1_bus_cycles", 0, abcd_cnt[0], 32'd3);
    chk("t1_be_n", 0, {30'd0, be_at_we[0]}, 32'd0);
    chk("t1_we_low", 1, we_low[1], 32'd1);
    chk("t1_bus_cycles", 1, abcd_cnt[1], 32'd2);

    // Read back: SRAM stand-in returns 0x00F0 at this address.
    clr_stats();
    send(1'b0, 18'h00012, 16'h0000, 2'b11);
    a1 = acc_cyc;
    idle(8);
    chk("t2_rsp_latency", 0, rsp_cyc[0] - a1, 32'd3);
    chk("t2_rdat", 0, {16'd0, rdat[0]}, 32'h00F0);
    chk("t2_oe_low", 0, oe_low[0], 32'd2);
    chk("t2_rsp_latency", 1, rsp_cyc[1] - a1, 32'd5);
    chk("t2_oe_low", 1, oe_low[1], 32'd4);

    // Byte enables: upper lane only, then no lanes with full timing.
    clr_stats();
    send(1'b1, 18'h00100, 16'h1234, 2'b10);
    idle(6);
    chk("t3_be_ub", 0, {30'd0, be_at_we[0]}, 32'd1);
    clr_stats();
    send(1'b1, 18'h00101, 16'h5678, 2'b00);
    idle(6);
    chk("t3_be_none", 0, {30'd0, be_at_we[0]}, 32'd3);
    chk("t3_we_low", 0, we_low[0], 32'd2);
    clr_stats();
    send(1'b0, 18'h00005, 16'h0000, 2'b00);
    idle(8);
    chk("t3_rsp_no_lanes", 0, rsp_cnt[0], 32'd1);

    // Reset during the second READ cycle aborts without a response.
    clr_stats();
    send(1'b0, 18'h00200, 16'h0000, 2'b11);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    idle(6);
    chk("t4_no_rsp", 0, rsp_cnt[0], 32'd0);
    chk("t4_no_rsp", 1, rsp_cnt[1], 32'd0);
    chk("t4_ready", 0, {31'd0, ready[0]}, 32'd1);

    // Write followed immediately by a read.
    clr_stats();
    send(1'b1, 18'h00300, 16'hBEEF, 2'b11);
    a1 = acc_cyc;
    send(1'b0, 18'h00300, 16'h0000, 2'b11);
    idle(10);
`ifdef SRAM_CTRL_TURNAROUND_EN
    chk("t5_first_oe", 0, first_oe[0] - a1, 32'd6);
`else
    chk("t5_first_oe", 0, first_oe[0] - a1, 32'd5);
`endif

    // Back-to-back reads: second accept lands on the first response cycle.
    clr_stats();
    send(1'b0, 18'h00020, 16'h0000, 2'b11);
    a1 = acc_cyc;
    send(1'b0, 18'h00021, 16'h0000, 2'b11);
    a2 = acc_cyc;
    idle(10);
    chk("bb_accept_gap", 0, a2 - a1, 32'd3);
    chk("bb_rdat", 0, {16'd0, rdat[0]}, 32'h00C3);
    chk("bb_rsp_count", 0, rsp_cnt[0], 32'd2);

    // Top of the address space on the long-read instance.
    clr_stats();
    send(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
    idle(10);
    chk("t6_adr", 1, {14'd0, adr[1]}, 32'h3FFFF);
    chk("t6_oe_low", 1, oe_low[1], 32'd4);
    chk("t6_rdat", 1, {16'd0, rdat[1]}, 32'hFF1D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

endmodule
